// File: rtl/sdram_port_arbiter_if.sv
// ==========================================================================
// sdram_port_arbiter_if : requester-side and controller-side bus of the arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

interface sdram_port_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 32
);
   logic [NUM_PORTS-1:0]        req_valid;
   logic [NUM_PORTS-1:0]        req_rw;
   logic [NUM_PORTS*ADDR_W-1:0] req_addr;
   logic [NUM_PORTS*DATA_W-1:0] req_wdata;
   logic [NUM_PORTS-1:0]        req_ready;
   logic [NUM_PORTS-1:0]        rsp_valid;
   logic                        rsp_err;
   logic [DATA_W-1:0]           rsp_rdata;
   logic [ADDR_W-1:0]           ctrl_addr;
   logic                        ctrl_rw;
   logic [DATA_W-1:0]           ctrl_wdata;
   logic                        ctrl_in_valid;
   logic                        ctrl_busy;
   logic [DATA_W-1:0]           ctrl_rdata;
   logic                        ctrl_out_valid;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata,
      output ctrl_busy, ctrl_rdata, ctrl_out_valid,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata,
      input  ctrl_busy, ctrl_rdata, ctrl_out_valid,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid
   );
endinterface

`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
// ==========================================================================
// sdram_port_arbiter : round-robin sharing of one sdram_controller user port
// Rev 1.0
// ==========================================================================
`default_nettype none

module sdram_port_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 32,
   parameter int RD_TIMEOUT = 64
) (
   input  wire logic           clk,
   input  wire logic           rst,
   sdram_port_arbiter_if.slave bus
);
   localparam int C_PTR_W = (NUM_PORTS > 2) ? 2 : 1;
   localparam int C_CNT_W = $clog2(RD_TIMEOUT);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(RD_TIMEOUT - 1);

   localparam logic [1:0] C_IDLE    = 2'd0;
   localparam logic [1:0] C_ISSUE   = 2'd1;
   localparam logic [1:0] C_SETTLE  = 2'd2;
   localparam logic [1:0] C_WAIT_RD = 2'd3;

   logic [1:0]           state_q,         state_d;
   logic [C_PTR_W-1:0]   rr_ptr_q,        rr_ptr_d;
   logic [C_PTR_W-1:0]   grant_q,         grant_d;
   logic [C_CNT_W-1:0]   cnt_q,           cnt_d;
   logic [ADDR_W-1:0]    ctrl_addr_q,     ctrl_addr_d;
   logic                 ctrl_rw_q,       ctrl_rw_d;
   logic [DATA_W-1:0]    ctrl_wdata_q,    ctrl_wdata_d;
   logic                 ctrl_in_valid_q, ctrl_in_valid_d;
   logic [NUM_PORTS-1:0] req_ready_q,     req_ready_d;
   logic [NUM_PORTS-1:0] rsp_valid_q,     rsp_valid_d;
   logic                 rsp_err_q,       rsp_err_d;
   logic [DATA_W-1:0]    rsp_rdata_q,     rsp_rdata_d;

   logic                 w_any_req;
   logic                 w_start;
   logic [C_PTR_W-1:0]   w_sel;
   logic [C_PTR_W:0]     w_sum;
   logic [C_PTR_W-1:0]   w_idx;

   // First requester after the last grant, wrapping modulo NUM_PORTS.
   always_comb begin : p_select
      w_any_req = 1'b0;
      w_sel     = rr_ptr_q;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         w_sum = {1'b0, rr_ptr_q} + (C_PTR_W+1)'(k);
         if (w_sum >= (C_PTR_W+1)'(NUM_PORTS)) begin
            w_sum = w_sum - (C_PTR_W+1)'(NUM_PORTS);
         end
         w_idx = w_sum[C_PTR_W-1:0];
         if (!w_any_req && bus.req_valid[w_idx]) begin
            w_any_req = 1'b1;
            w_sel     = w_idx;
         end
      end
   end

   assign w_start = (state_q == C_IDLE) && w_any_req && !bus.ctrl_busy;

   always_ff @(posedge clk) begin : p_state_reg
      if (rst) begin
         state_q         <= C_IDLE;
         rr_ptr_q        <= C_PTR_W'(NUM_PORTS - 1);
         grant_q         <= '0;
         cnt_q           <= '0;
         ctrl_addr_q     <= '0;
         ctrl_rw_q       <= 1'b0;
         ctrl_wdata_q    <= '0;
         ctrl_in_valid_q <= 1'b0;
         req_ready_q     <= '0;
         rsp_valid_q     <= '0;
         rsp_err_q       <= 1'b0;
         rsp_rdata_q     <= '0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         grant_q         <= grant_d;
         cnt_q           <= cnt_d;
         ctrl_addr_q     <= ctrl_addr_d;
         ctrl_rw_q       <= ctrl_rw_d;
         ctrl_wdata_q    <= ctrl_wdata_d;
         ctrl_in_valid_q <= ctrl_in_valid_d;
         req_ready_q     <= req_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_err_q       <= rsp_err_d;
         rsp_rdata_q     <= rsp_rdata_d;
      end
   end

   always_comb begin : p_next_state
      state_d = state_q;
      case (state_q)
         C_IDLE:    if (w_start) state_d = C_ISSUE;
         C_ISSUE:   state_d = C_SETTLE;
         C_SETTLE:  state_d = ctrl_rw_q ? C_IDLE : C_WAIT_RD;
         C_WAIT_RD: if (bus.ctrl_out_valid || (cnt_q == C_CNT_LAST)) state_d = C_IDLE;
         default:   state_d = C_IDLE;
      endcase
   end

   // Outputs are registered, so their pulses are set on the transition into the state.
   always_comb begin : p_outputs
      rr_ptr_d        = rr_ptr_q;
      grant_d         = grant_q;
      cnt_d           = cnt_q;
      ctrl_addr_d     = ctrl_addr_q;
      ctrl_rw_d       = ctrl_rw_q;
      ctrl_wdata_d    = ctrl_wdata_q;
      ctrl_in_valid_d = 1'b0;
      req_ready_d     = '0;
      rsp_valid_d     = '0;
      rsp_err_d       = rsp_err_q;
      rsp_rdata_d     = rsp_rdata_q;
      case (state_q)
         C_IDLE: begin
            if (w_start) begin
               grant_d         = w_sel;
               rr_ptr_d        = w_sel;
               ctrl_addr_d     = bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
               ctrl_rw_d       = bus.req_rw[w_sel];
               ctrl_wdata_d    = bus.req_wdata[int'(w_sel)*DATA_W +: DATA_W];
               ctrl_in_valid_d = 1'b1;
               req_ready_d     = NUM_PORTS'(1) << w_sel;
            end
         end
         C_SETTLE: cnt_d = '0;
         C_WAIT_RD: begin
            // Data arriving on the expiry cycle still counts as a good response.
            if (bus.ctrl_out_valid) begin
               rsp_valid_d = NUM_PORTS'(1) << grant_q;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = bus.ctrl_rdata;
            end else if (cnt_q == C_CNT_LAST) begin
               rsp_valid_d = NUM_PORTS'(1) << grant_q;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.ctrl_addr     = ctrl_addr_q;
   assign bus.ctrl_rw       = ctrl_rw_q;
   assign bus.ctrl_wdata    = ctrl_wdata_q;
   assign bus.ctrl_in_valid = ctrl_in_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
// ==========================================================================
// tb_sdram_port_arbiter : directed bench with requester, controller stub and logs
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_sdram_port_arbiter;
   localparam int NP  = 2;
   localparam int AW  = 23;
   localparam int DW  = 32;
   localparam int RDT = 64;

   typedef struct packed {logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata;} txn_t;
   typedef struct packed {logic [7:0] port; logic [31:0] cyc; logic iv;} glog_t;
   typedef struct packed {logic [7:0] port; logic [DW-1:0] data; logic err; logic [31:0] cyc;} rlog_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(RDT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Controller stub: busy for 4 cycles per command, read data rd_lat cycles after issue.
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic          stub_busy  = 1'b0;
   logic          force_busy = 1'b0;
   int            rd_lat     = 5;
   int            busy_cnt   = 0;
   int            rd_cnt     = 0;
   logic [AW-1:0] rd_addr    = '0;

   assign bus.ctrl_busy = stub_busy | force_busy;

   initial begin
      bus.ctrl_out_valid = 1'b0;
      bus.ctrl_rdata     = '0;
      forever begin
         @(posedge clk); #1;
         bus.ctrl_out_valid = 1'b0;
         if (rst) begin
            stub_busy = 1'b0;
            busy_cnt  = 0;
            rd_cnt    = 0;
         end else begin
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) stub_busy = 1'b0;
            end
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) begin
                  bus.ctrl_out_valid = 1'b1;
                  bus.ctrl_rdata = mem.exists(rd_addr) ? mem[rd_addr] : {9'd0, rd_addr};
               end
            end
            if (bus.ctrl_in_valid) begin
               stub_busy = 1'b1;
               busy_cnt  = 4;
               if (bus.ctrl_rw) mem[bus.ctrl_addr] = bus.ctrl_wdata;
               else begin
                  rd_addr = bus.ctrl_addr;
                  rd_cnt  = rd_lat;
               end
            end
         end
      end
   end

   // Requesters: present queued transactions in order, hold each until accepted.
   txn_t pq [NP][$];
   int   rdi [NP];

   initial begin
      bus.req_valid = '0;
      bus.req_rw    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int p = 0; p < NP; p++) rdi[p] = 0;
      forever begin
         @(posedge clk); #1;
         for (int p = 0; p < NP; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p]) begin
               bus.req_valid[p] = 1'b0;
               rdi[p]++;
            end
            if (!bus.req_valid[p] && rdi[p] < pq[p].size()) begin
               bus.req_valid[p]           = 1'b1;
               bus.req_rw[p]              = pq[p][rdi[p]].rw;
               bus.req_addr[p*AW +: AW]   = pq[p][rdi[p]].addr;
               bus.req_wdata[p*DW +: DW]  = pq[p][rdi[p]].wdata;
            end
         end
      end
   end

   function automatic int oh2i(input logic [NP-1:0] v);
      if ($countones(v) != 1) return 99;
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return 99;
   endfunction

   // Monitor: grant / response / issue logs and the hold-until-ready rule.
   glog_t         gl [$];
   rlog_t         rl [$];
   int            il [$];
   int            rise_cyc [NP];
   int            viol = 0;
   logic [NP-1:0] prev_v = '0;
   logic [NP-1:0] prev_r = '0;

   initial begin
      glog_t g;
      rlog_t r;
      forever begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            g.port = 8'(oh2i(bus.req_ready));
            g.cyc  = cyc;
            g.iv   = bus.ctrl_in_valid;
            gl.push_back(g);
         end
         if (bus.rsp_valid != '0) begin
            r.port = 8'(oh2i(bus.rsp_valid));
            r.data = bus.rsp_rdata;
            r.err  = bus.rsp_err;
            r.cyc  = cyc;
            rl.push_back(r);
         end
         if (bus.ctrl_in_valid) il.push_back(cyc);
         for (int p = 0; p < NP; p++) begin
            if (bus.req_valid[p] && !prev_v[p]) rise_cyc[p] = cyc;
            if (!rst && prev_v[p] && !prev_r[p] && !bus.req_valid[p] && !bus.req_ready[p]) viol++;
         end
         prev_v = bus.req_valid;
         prev_r = bus.req_ready;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic push_txn(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.rw = rw; t.addr = a; t.wdata = d;
      pq[p].push_back(t);
   endtask

   task automatic wait_grant(input int n, input int budget);
      int k = 0;
      while (gl.size() < n && k < budget) begin tick(1); k++; end
      if (gl.size() < n) check_val("wait_grant", 64'(gl.size()), 64'(n));
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int k = 0;
      while (rl.size() < n && k < budget) begin tick(1); k++; end
      if (rl.size() < n) check_val("wait_rsp", 64'(rl.size()), 64'(n));
   endtask

   task automatic check_outs_zero(input string tag);
      check_val({tag, "_pulses"}, {bus.ctrl_in_valid, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.ctrl_rw}, '0);
      check_val({tag, "_addr"}, 64'(bus.ctrl_addr), 64'h0);
      check_val({tag, "_data"}, {bus.ctrl_wdata, bus.rsp_rdata}, 64'h0);
   endtask

   initial begin
      int g0, r0, i0, fall;
      tick(3);
      check_outs_zero("reset");
      rst = 1'b0;
      tick(1);

      // single posted write from port 1
      push_txn(1, 1'b1, 23'h001234, 32'hDEADBEEF);
      wait_grant(1, 20);
      check_val("wr_port", 64'(gl[0].port), 64'd1);
      check_val("wr_ready_with_in_valid", 64'(gl[0].iv), 64'd1);
      check_val("wr_latency", 64'(int'(gl[0].cyc) - rise_cyc[1]), 64'd1);
      check_val("wr_ctrl_addr", 64'(bus.ctrl_addr), 64'h001234);
      check_val("wr_ctrl_rw", 64'(bus.ctrl_rw), 64'd1);
      check_val("wr_ctrl_wdata", 64'(bus.ctrl_wdata), 64'hDEADBEEF);
      tick(10);
      check_val("wr_no_rsp", 64'(rl.size()), 64'd0);
      check_val("wr_addr_held", 64'(bus.ctrl_addr), 64'h001234);

      // read back through port 0
      push_txn(0, 1'b0, 23'h001234, '0);
      wait_rsp(1, 40);
      check_val("rd_grant", 64'(gl[1].port), 64'd0);
      check_val("rd_rsp_port", 64'(rl[0].port), 64'd0);
      check_val("rd_rsp_data", 64'(rl[0].data), 64'hDEADBEEF);
      check_val("rd_rsp_err", 64'(rl[0].err), 64'd0);

      // reset while a port-0 read waits for data
      push_txn(0, 1'b0, 23'h000055, '0);
      wait_grant(3, 20);
      tick(4);
      rst = 1'b1;
      tick(1);
      check_outs_zero("midrst");
      tick(2);
      rst = 1'b0;
      tick(10);
      check_val("midrst_no_rsp", 64'(rl.size()), 64'd1);
      check_val("midrst_no_ready", 64'(gl.size()), 64'd3);

      // contention from reset: 4 reads per port
      for (int i = 0; i < 4; i++) begin
         push_txn(0, 1'b0, 23'h000100 + 23'(i), '0);
         push_txn(1, 1'b0, 23'h000200 + 23'(i), '0);
      end
      wait_rsp(9, 300);
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("rr_grant%0d", i), 64'(gl[3+i].port), 64'(i % 2));
         check_val($sformatf("rr_rsp_port%0d", i), 64'(rl[1+i].port), 64'(i % 2));
         check_val($sformatf("rr_rsp_data%0d", i), 64'(rl[1+i].data),
                   64'((i % 2 == 0) ? 32'h100 + 32'(i/2) : 32'h200 + 32'(i/2)));
      end

      // busy gating
      force_busy = 1'b1;
      tick(2);
      g0 = gl.size();
      i0 = il.size();
      push_txn(0, 1'b1, 23'h000300, 32'h1111_0000);
      push_txn(1, 1'b1, 23'h000301, 32'h2222_0000);
      tick(20);
      check_val("busy_no_issue", 64'(il.size()), 64'(i0));
      fall = cyc;
      force_busy = 1'b0;
      wait_grant(g0 + 2, 40);
      check_val("busy_issue_cycle", 64'(il[i0]), 64'(fall + 1));
      check_val("busy_grant0", 64'(gl[g0].port), 64'd0);
      check_val("busy_grant1", 64'(gl[g0+1].port), 64'd1);
      check_val("b2b_gap_ge3", 64'((il[i0+1] - il[i0]) >= 3), 64'd1);
      tick(10);

      // timeout: data would arrive one cycle too late and must be ignored
      rd_lat = RDT + 2;
      g0 = gl.size();
      r0 = rl.size();
      push_txn(1, 1'b0, 23'h000300, '0);
      wait_rsp(r0 + 1, 120);
      check_val("tmo_port", 64'(rl[r0].port), 64'd1);
      check_val("tmo_err", 64'(rl[r0].err), 64'd1);
      check_val("tmo_data", 64'(rl[r0].data), 64'h0);
      check_val("tmo_cycle", 64'(int'(rl[r0].cyc) - int'(gl[g0].cyc)), 64'(RDT + 2));
      tick(20);
      check_val("tmo_late_ignored", 64'(rl.size()), 64'(r0 + 1));

      // data on the expiry cycle wins over the timeout
      rd_lat = RDT + 1;
      g0 = gl.size();
      push_txn(0, 1'b0, 23'h000301, '0);
      wait_rsp(r0 + 2, 120);
      check_val("tie_port", 64'(rl[r0+1].port), 64'd0);
      check_val("tie_err", 64'(rl[r0+1].err), 64'd0);
      check_val("tie_data", 64'(rl[r0+1].data), 64'h2222_0000);
      check_val("tie_cycle", 64'(int'(rl[r0+1].cyc) - int'(gl[g0].cyc)), 64'(RDT + 2));
      tick(5);

      check_val("req_hold_protocol", 64'(viol), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
